keypad_input: RTL and testbench

KEYPAD_INPUT -- requirements
Module: keypad_input

---
 rtl/keypad_input_pkg.sv | 25 ++
 rtl/keypad_input_scan_tick.sv | 23 ++
 rtl/keypad_input.sv | 126 ++++++++++++
 tb/tb_keypad_input.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_input_pkg.sv
// keypad_input_pkg: shared FSM states, row drive constants and key code helpers
package keypad_input_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HOLD
    } state_t;

    localparam logic [3:0] ROW0 = 4'b1110;
    localparam logic [3:0] ROW1 = 4'b1101;
    localparam logic [3:0] ROW2 = 4'b1011;
    localparam logic [3:0] ROW3 = 4'b0111;

    // Hex value of the key at row r, column c is simply 4*r + c.
    function automatic logic [3:0] key_hex(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

    // Index of the lowest zero bit; used on one-cold rows and single-low columns.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/keypad_input_scan_tick.sv
// scan_tick_gen: free-running prescaler, tick when the counter is all-ones
module scan_tick_gen #(
    parameter int TICK_W = 11
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [TICK_W-1:0] cnt_q, cnt_d;

    // Next prescaler value; wraps naturally at 2^TICK_W.
    always_comb cnt_d = cnt_q + TICK_W'(1);

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/keypad_input.sv
// keypad_input: 4x4 keypad scanner with debounce, hex digit shift register
module keypad_input
    import keypad_input_pkg::*;
#(
    parameter int TICK_W   = 11,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    input  logic        clear,
    output logic [31:0] data,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    localparam logic [3:0] DB = 4'(DEBOUNCE);

    logic        tick;
    logic [3:0]  col_s1_q, col_s2_q;
    state_t      state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  cap_q, cap_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  key_code_q, key_code_d;
    logic [31:0] data_q, data_d;
    logic        key_valid_q, key_valid_d;
    logic [3:0]  cnt_inc, rot, hex;
    logic        one_low, accept;

    scan_tick_gen #(.TICK_W(TICK_W)) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Two-flop synchroniser on the column sense lines; idle level is all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
        end else begin
            col_s1_q <= col;
            col_s2_q <= col_s1_q;
        end
    end

    // Scan/debounce/hold decisions on ticks; accept loads the code and data shift.
    always_comb begin
        cnt_inc = cnt_q + 4'd1;
        rot     = {row_q[2:0], row_q[3]};
        one_low = $countones(~col_s2_q) == 1;
        hex     = key_hex(low_idx(row_q), low_idx(col_s2_q));
        state_d = state_q;
        row_d   = row_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (one_low) begin
                        cap_d   = col_s2_q;
                        accept  = DB == 4'd1;
                        cnt_d   = accept ? 4'd0 : 4'd1;
                        state_d = accept ? ST_HOLD : ST_DEBOUNCE;
                    end else begin
                        row_d = rot;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_s2_q == cap_q) begin
                        accept  = cnt_inc == DB;
                        cnt_d   = accept ? 4'd0 : cnt_inc;
                        state_d = accept ? ST_HOLD : ST_DEBOUNCE;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = ST_SCAN;
                        row_d   = rot;
                    end
                end
                ST_HOLD: begin
                    if (col_s2_q == 4'hF) begin
                        cnt_d   = cnt_inc == DB ? 4'd0 : cnt_inc;
                        state_d = cnt_inc == DB ? ST_SCAN : ST_HOLD;
                        row_d   = cnt_inc == DB ? rot : row_q;
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
        key_valid_d = accept;
        key_code_d  = accept ? hex : key_code_q;
        data_d      = clear ? 32'h0 : accept ? {data_q[27:0], hex} : data_q;
    end

    // State, row drive, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            row_q       <= ROW0;
            cap_q       <= 4'hF;
            cnt_q       <= 4'd0;
            key_code_q  <= 4'd0;
            data_q      <= 32'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cap_q       <= cap_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            data_q      <= data_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign row       = row_q;
    assign data      = data_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_input.sv
// tb_keypad_input: scenario tasks plus randomized run against a behavioural keypad model
module tb_keypad_input;

    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [31:0] data;
    logic        key_valid;
    logic [3:0]  key_code;

    logic        key_down = 1'b0;
    logic [1:0]  kr = 2'd0, kc = 2'd0;
    logic [3:0]  raw_col = 4'hF;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Physical keypad: a closed key pulls its column low only while its row is driven.
    assign col = (key_down && row == ~(4'b0001 << kr)) ? ~(4'b0001 << kc) : raw_col;

    keypad_input #(.TICK_W(2), .DEBOUNCE(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .col      (col),
        .row      (row),
        .clear    (clear),
        .data     (data),
        .key_valid(key_valid),
        .key_code (key_code)
    );

    // Reference model: tick every 4th clock, 2-clock sense delay, mode 0/1/2 = scan/debounce/hold.
    int          m_pre, m_r, m_mode, m_cnt, m_lows, m_ci;
    logic [3:0]  m_c1, m_c2, m_cs, m_cap, m_code;
    logic [31:0] m_data;
    bit          m_valid, m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pre = 0; m_r = 0; m_mode = 0; m_cnt = 0;
            m_c1 = 4'hF; m_c2 = 4'hF; m_cap = 4'hF;
            m_code = 4'h0; m_data = 32'h0; m_valid = 0;
        end else begin
            m_cs = m_c2;
            m_acc = 0;
            if (m_pre == 3) begin
                m_lows = 0;
                m_ci = 0;
                for (int i = 3; i >= 0; i--) if (!m_cs[i]) begin m_lows++; m_ci = i; end
                if (m_mode == 0) begin
                    if (m_lows == 1) begin
                        m_cap = m_cs; m_cnt = 1; m_mode = 1;
                        if (DB == 1) begin m_acc = 1; m_mode = 2; m_cnt = 0; end
                    end else m_r = (m_r + 1) % 4;
                end else if (m_mode == 1) begin
                    if (m_cs == m_cap) begin
                        m_cnt++;
                        if (m_cnt == DB) begin m_acc = 1; m_mode = 2; m_cnt = 0; end
                    end else begin
                        m_mode = 0; m_cnt = 0; m_r = (m_r + 1) % 4;
                    end
                end else begin
                    if (m_cs == 4'hF) begin
                        m_cnt++;
                        if (m_cnt == DB) begin m_mode = 0; m_cnt = 0; m_r = (m_r + 1) % 4; end
                    end else m_cnt = 0;
                end
            end
            if (m_acc) begin
                m_code = 4'(4 * m_r + m_ci);
                m_data = {m_data[27:0], m_code};
            end
            if (clear) m_data = 32'h0;
            m_valid = m_acc;
            m_c2 = m_c1;
            m_c1 = col;
            m_pre = (m_pre + 1) % 4;
        end
    end

    task automatic press_key(input logic [3:0] h, output int pulses, output logic [3:0] code);
        pulses = 0;
        code = 4'h0;
        kr = h[3:2];
        kc = h[1:0];
        key_down = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (key_valid) begin pulses++; code = key_code; end
        end
        key_down = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (key_valid) pulses++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (row !== 4'b1110) begin bad++; $display("FAIL reset_row got=%b exp=1110", row); end
        total++; if (data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        total++; if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code got=%h exp=0", key_code); end
        rst = 1'b0;
    endtask

    task automatic test_idle;
        int changes;
        logic [3:0] prev;
        changes = 0;
        prev = row;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (row !== prev) begin
                changes++;
                total++; if (row !== {prev[2:0], prev[3]}) begin bad++; $display("FAIL idle_rotate got=%b prev=%b", row, prev); end
            end
            prev = row;
            total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", key_valid); end
        end
        total++; if (changes != 10) begin bad++; $display("FAIL idle_changes got=%0d exp=10", changes); end
        total++; if (row !== 4'b1011) begin bad++; $display("FAIL idle_row got=%b exp=1011", row); end
        total++; if (data !== 32'h0) begin bad++; $display("FAIL idle_data got=%h exp=0", data); end
    endtask

    task automatic test_press;
        int pulses;
        pulses = 0;
        kr = 2'd2; kc = 2'd1; key_down = 1'b1;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (key_valid) begin
                pulses++;
                total++; if (key_code !== 4'h9) begin bad++; $display("FAIL press_code got=%h exp=9", key_code); end
                total++; if (data !== 32'h9) begin bad++; $display("FAIL press_data got=%h exp=00000009", data); end
            end
            if (pulses > 0) begin
                total++; if (row !== 4'b1011) begin bad++; $display("FAIL press_frozen got=%b exp=1011", row); end
            end
        end
        key_down = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (key_valid) pulses++;
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL press_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_bounce;
        int pulses, changes, guard;
        logic [3:0] prev, code;
        guard = 0;
        while (row === 4'b1011 && guard < 40) begin @(negedge clk); guard++; end
        while (row !== 4'b1011 && guard < 40) begin @(negedge clk); guard++; end
        total++; if (row !== 4'b1011) begin bad++; $display("FAIL bounce_sync got=%b exp=1011", row); end
        kr = 2'd2; kc = 2'd1; key_down = 1'b1;
        repeat (4) @(negedge clk);
        key_down = 1'b0;
        pulses = 0;
        changes = 0;
        prev = row;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (key_valid) pulses++;
            if (row !== prev) changes++;
            prev = row;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL bounce_pulses got=%0d exp=0", pulses); end
        total++; if (changes != 10) begin bad++; $display("FAIL bounce_rescan got=%0d exp=10", changes); end
        press_key(4'hF, pulses, code);
        total++; if (pulses != 1) begin bad++; $display("FAIL bounce_f_pulses got=%0d exp=1", pulses); end
        total++; if (code !== 4'hF) begin bad++; $display("FAIL bounce_f_code got=%h exp=f", code); end
        total++; if (data !== 32'h9F) begin bad++; $display("FAIL bounce_data got=%h exp=0000009f", data); end
    endtask

    task automatic test_multi;
        int pulses, changes;
        logic [3:0] prev;
        raw_col = 4'b1001;
        pulses = 0;
        changes = 0;
        prev = row;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (key_valid) pulses++;
            if (row !== prev) changes++;
            prev = row;
        end
        raw_col = 4'hF;
        total++; if (pulses != 0) begin bad++; $display("FAIL multi_pulses got=%0d exp=0", pulses); end
        total++; if (changes != 10) begin bad++; $display("FAIL multi_rotate got=%0d exp=10", changes); end
        total++; if (data !== 32'h9F) begin bad++; $display("FAIL multi_data got=%h exp=0000009f", data); end
    endtask

    task automatic test_wrap;
        int pulses;
        logic [3:0] code;
        logic [3:0] seq [9];
        seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA};
        for (int i = 0; i < 9; i++) begin
            press_key(seq[i], pulses, code);
            total++; if (pulses != 1 || code !== seq[i]) begin
                bad++; $display("FAIL wrap_key%0d got=%h/%0d exp=%h/1", i, code, pulses, seq[i]);
            end
        end
        total++; if (data !== 32'h2345678A) begin bad++; $display("FAIL wrap_data got=%h exp=2345678a", data); end
    endtask

    task automatic test_clear;
        bit seen;
        int pulses;
        logic [3:0] code;
        seen = 0;
        clear = 1'b1;
        kr = 2'd1; kc = 2'd1; key_down = 1'b1;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (key_valid) begin
                seen = 1;
                total++; if (data !== 32'h0) begin bad++; $display("FAIL clear_data got=%h exp=0", data); end
                total++; if (key_code !== 4'h5) begin bad++; $display("FAIL clear_code got=%h exp=5", key_code); end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL clear_valid got=0 exp=1"); end
        clear = 1'b0;
        key_down = 1'b0;
        repeat (40) @(negedge clk);
        press_key(4'h7, pulses, code);
        total++; if (data !== 32'h7 || pulses != 1) begin bad++; $display("FAIL clear_after got=%h/%0d exp=00000007/1", data, pulses); end
    endtask

    task automatic test_rst_hold;
        bit seen;
        int n;
        seen = 0;
        kr = 2'd1; kc = 2'd2; key_down = 1'b1;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (key_valid) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL rst_first_valid got=0 exp=1"); end
        rst = 1'b1;
        #1;
        total++; if (row !== 4'b1110) begin bad++; $display("FAIL rst_row got=%b exp=1110", row); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", key_valid); end
        total++; if (data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", data); end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        seen = 0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            @(negedge clk);
            if (key_valid) begin seen = 1; n = k; end
        end
        total++; if (n != 16) begin bad++; $display("FAIL rst_redetect got=%0d exp=16", n); end
        total++; if (key_code !== 4'h6 || data !== 32'h6) begin bad++; $display("FAIL rst_new_key got=%h/%h exp=6/00000006", key_code, data); end
        key_down = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_random;
        int act, dur;
        logic [3:0] exp_row, v;
        for (int it = 0; it < 60; it++) begin
            act = $urandom_range(0, 9);
            key_down = 1'b0;
            raw_col = 4'hF;
            if (act <= 5) begin
                v = 4'($urandom_range(0, 15));
                kr = v[3:2]; kc = v[1:0]; key_down = 1'b1;
            end else if (act <= 7) begin
                v = 4'($urandom_range(0, 15));
                while ($countones(~v) < 2) v = 4'($urandom_range(0, 15));
                raw_col = v;
            end else if (act == 9) begin
                rst = 1'b1;
            end
            dur = $urandom_range(1, 60);
            for (int ph = 0; ph < 2; ph++) begin
                for (int k = 0; k < dur; k++) begin
                    @(negedge clk);
                    exp_row = ~(4'b0001 << m_r);
                    total++; if (row !== exp_row) begin bad++; $display("FAIL rand_row it=%0d got=%b exp=%b", it, row, exp_row); end
                    total++; if (key_valid !== m_valid) begin bad++; $display("FAIL rand_valid it=%0d got=%b exp=%b", it, key_valid, m_valid); end
                    total++; if (key_code !== m_code) begin bad++; $display("FAIL rand_code it=%0d got=%h exp=%h", it, key_code, m_code); end
                    total++; if (data !== m_data) begin bad++; $display("FAIL rand_data it=%0d got=%h exp=%h", it, data, m_data); end
                    clear = ($urandom_range(0, 15) == 0);
                    rst = 1'b0;
                end
                key_down = 1'b0;
                raw_col = 4'hF;
                dur = $urandom_range(1, 50);
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press();
        test_bounce();
        test_multi();
        test_wrap();
        test_clear();
        test_rst_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
